// File: rtl/rr_encoder_32x5.sv
// rr_encoder_32x5: round-robin 32-to-5 encoder with a pending set and a valid/ready output
module rr_encoder_32x5 (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] REQ,
  input  logic        OUT_READY,
  output logic        OUT_VALID,
  output logic [4:0]  IDX,
  output logic [31:0] PEND,
  output logic [4:0]  PTR
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state, state_nx;
  logic [31:0] cand, rot;
  logic [63:0] dbl;
  logic [4:0]  off, w;
  logic        load, any;
  assign cand = PEND | REQ;
  assign any  = |cand;
  assign load = (state == EMPTY) || OUT_READY;
  assign OUT_VALID = (state == FULL);
  // Rotate so PTR lands on bit 0; the lowest set bit is then the winner's offset from PTR.
  assign dbl = {cand, cand} >> PTR;
  assign rot = dbl[31:0];
  assign w = PTR + off;
  always_comb begin
    off = '0;
    for (int i = 31; i >= 0; i--)
      if (rot[i]) off = i[4:0];
  end
  always_comb begin
    state_nx = state;
    if (load) state_nx = any ? FULL : EMPTY;
  end
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= EMPTY;
      IDX   <= '0;
      PEND  <= '0;
      PTR   <= '0;
    end else begin
      state <= state_nx;
      if (load && any) begin
        IDX  <= w;
        PEND <= cand & ~(32'd1 << w);
        PTR  <= w + 5'd1;
      end else if (!load) begin
        PEND <= cand;
      end
    end
  end
endmodule

// File: tb/tb_rr_encoder_32x5.sv
// tb_rr_encoder_32x5: directed checks of grant order, back-pressure, coalescing and reset.
module tb_rr_encoder_32x5;
  logic        clk = 0;
  logic        rst_n = 0;
  logic [31:0] req = '0;
  logic        rdy = 0;
  logic        vld;
  logic [4:0]  idx, ptr;
  logic [31:0] pend;
  int n_cmp = 0;
  int n_bad = 0;

  rr_encoder_32x5 dut (
    .CLK(clk), .RESET(rst_n), .REQ(req), .OUT_READY(rdy),
    .OUT_VALID(vld), .IDX(idx), .PEND(pend), .PTR(ptr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0; req = '0; rdy = 0;
    step(); step();
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0; req = 32'hFFFFFFFF; rdy = 1;
    repeat (3) step();
    n_cmp++; if (vld !== 1'b0) begin n_bad++; $display("FAIL reset_vld got %0b want 0", vld); end
    n_cmp++; if (idx !== 5'd0) begin n_bad++; $display("FAIL reset_idx got %0d want 0", idx); end
    n_cmp++; if (pend !== 32'h0) begin n_bad++; $display("FAIL reset_pend got %h want 0", pend); end
    n_cmp++; if (ptr !== 5'd0) begin n_bad++; $display("FAIL reset_ptr got %0d want 0", ptr); end
    req = '0; rst_n = 1;
    step(); step();
    n_cmp++; if (vld !== 1'b0) begin n_bad++; $display("FAIL release_vld got %0b want 0", vld); end
  endtask

  task automatic test_single();
    do_reset();
    req = 32'h00000400; rdy = 1;
    step();
    req = '0;
    n_cmp++; if (vld !== 1'b1) begin n_bad++; $display("FAIL single_vld got %0b want 1", vld); end
    n_cmp++; if (idx !== 5'd10) begin n_bad++; $display("FAIL single_idx got %0d want 10", idx); end
    n_cmp++; if (ptr !== 5'd11) begin n_bad++; $display("FAIL single_ptr got %0d want 11", ptr); end
    step();
    n_cmp++; if (vld !== 1'b0) begin n_bad++; $display("FAIL single_drop got %0b want 0", vld); end
    n_cmp++; if (pend !== 32'h0) begin n_bad++; $display("FAIL single_pend got %h want 0", pend); end
    n_cmp++; if (ptr !== 5'd11) begin n_bad++; $display("FAIL single_ptr_hold got %0d want 11", ptr); end
  endtask

  task automatic test_wrap();
    logic [4:0] exp [3];
    exp = '{5'd0, 5'd1, 5'd31};
    do_reset();
    req = 32'h80000003; rdy = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      req = '0;
      n_cmp++; if (vld !== 1'b1 || idx !== exp[k]) begin n_bad++; $display("FAIL wrap_idx%0d got %0b/%0d want 1/%0d", k, vld, idx, exp[k]); end
    end
    n_cmp++; if (ptr !== 5'd0) begin n_bad++; $display("FAIL wrap_ptr got %0d want 0", ptr); end
    step();
    n_cmp++; if (vld !== 1'b0) begin n_bad++; $display("FAIL wrap_drop got %0b want 0", vld); end
  endtask

  task automatic test_backpressure();
    do_reset();
    req = 32'h00000030; rdy = 0;
    step();
    req = '0;
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if (vld !== 1'b1 || idx !== 5'd4 || pend !== 32'h20 || ptr !== 5'd5) begin
        n_bad++; $display("FAIL bp_hold%0d got v=%0b i=%0d p=%h r=%0d want 1/4/00000020/5", k, vld, idx, pend, ptr);
      end
      step();
    end
    rdy = 1;
    step();
    n_cmp++; if (vld !== 1'b1 || idx !== 5'd5) begin n_bad++; $display("FAIL bp_next got %0b/%0d want 1/5", vld, idx); end
    n_cmp++; if (pend !== 32'h0 || ptr !== 5'd6) begin n_bad++; $display("FAIL bp_state got %h/%0d want 0/6", pend, ptr); end
    step();
    n_cmp++; if (vld !== 1'b0) begin n_bad++; $display("FAIL bp_drop got %0b want 0", vld); end
  endtask

  task automatic test_fairness();
    logic [4:0] exp [4];
    exp = '{5'd3, 5'd7, 5'd3, 5'd3};
    do_reset();
    req = 32'h00000088; rdy = 1;
    for (int k = 0; k < 4; k++) begin
      step();
      req = 32'h00000008;
      n_cmp++; if (vld !== 1'b1 || idx !== exp[k]) begin n_bad++; $display("FAIL fair_idx%0d got %0b/%0d want 1/%0d", k, vld, idx, exp[k]); end
    end
    req = '0;
    step();
    n_cmp++; if (vld !== 1'b0 || pend !== 32'h0) begin n_bad++; $display("FAIL fair_drop got %0b/%h want 0/0", vld, pend); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 32'h0000F000; rdy = 0;
    step();
    n_cmp++; if (idx !== 5'd12 || pend !== 32'h0000E000) begin n_bad++; $display("FAIL mid_load got %0d/%h want 12/0000e000", idx, pend); end
    req = 32'h00001000;
    step();
    req = '0;
    n_cmp++; if (vld !== 1'b1 || idx !== 5'd12 || pend !== 32'h0000F000) begin
      n_bad++; $display("FAIL mid_repend got %0b/%0d/%h want 1/12/0000f000", vld, idx, pend);
    end
    #2 rst_n = 0;
    #1;
    n_cmp++; if (vld !== 1'b0 || pend !== 32'h0 || ptr !== 5'd0 || idx !== 5'd0) begin
      n_bad++; $display("FAIL mid_async got v=%0b p=%h r=%0d i=%0d want 0/0/0/0", vld, pend, ptr, idx);
    end
    step();
    rst_n = 1;
    step();
    n_cmp++; if (vld !== 1'b0) begin n_bad++; $display("FAIL mid_after got %0b want 0", vld); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_backpressure();
    test_fairness();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
